// File: rtl/parking_lot_pkg.sv
// Shared types for the parking-lot gate direction detector: FSM state
// encoding and the {in_sig,out_sig} sensor codes.
package parking_lot_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6,
        SYNC = 3'd7
    } state_e;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S01 = 2'b01;

    // Outer beam is the MSB so codes read in the same order as the sensors.
    function automatic logic [1:0] sensor_code(input logic outer, input logic inner);
        return {outer, inner};
    endfunction

endpackage

// File: rtl/parking_lot_counter.sv
// Saturating occupancy counter with registered full/empty flags; only
// instantiated when PARKING_LOT_OCCUPANCY_EN is defined.
module parking_lot_counter
    import parking_lot_pkg::*;
#(
    parameter int CAPACITY = 16,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             full_r;
    logic             empty_r;

    // Next count: saturate at CAPACITY on entry and at zero on exit.
    always_comb begin
        count_nxt_s = count_r;
        if (inc && (count_r != CAP_C)) begin
            count_nxt_s = count_r + ONE_C;
        end else if (dec && (count_r != ZERO_C)) begin
            count_nxt_s = count_r - ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count and flags registered together so they never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= ZERO_C;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CAP_C);
            empty_r <= (count_nxt_s == ZERO_C);
        end
    end

    assign count = count_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/parking_lot_fsm_single.sv
// Two-beam gate direction detector emitting one-cycle entering/exiting pulses.
// Occupancy counting is enabled by defining PARKING_LOT_OCCUPANCY_EN.
module parking_lot_fsm_single
    import parking_lot_pkg::*;
#(
    parameter int CAPACITY = 16,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_sig,
    input  logic             out_sig,
    output logic             entering,
    output logic             exiting,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    state_e     state_r;
    logic [1:0] code_s;
    logic       inc_s;
    logic       dec_s;

    assign code_s = sensor_code(in_sig, out_sig);

    // Crossing completes when both beams clear from the last step of a path.
    always_comb begin
        inc_s = 1'b0;
        dec_s = 1'b0;
        if (code_s == S00) begin
            inc_s = (state_r == EN3);
            dec_s = (state_r == EX3);
        end else begin
            inc_s = 1'b0;
            dec_s = 1'b0;
        end
    end

    // Sequence tracker with registered direction pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            entering <= 1'b0;
            exiting  <= 1'b0;
        end else begin
            entering <= inc_s;
            exiting  <= dec_s;
            case (state_r)
                IDLE: begin
                    case (code_s)
                        S10:     state_r <= EN1;
                        S01:     state_r <= EX1;
                        S11:     state_r <= SYNC;
                        default: state_r <= IDLE;
                    endcase
                end
                EN1: begin
                    case (code_s)
                        S11:     state_r <= EN2;
                        S00:     state_r <= IDLE;
                        S01:     state_r <= SYNC;
                        default: state_r <= EN1;
                    endcase
                end
                EN2: begin
                    case (code_s)
                        S01:     state_r <= EN3;
                        S10:     state_r <= EN1;
                        S00:     state_r <= SYNC;
                        default: state_r <= EN2;
                    endcase
                end
                EN3: begin
                    case (code_s)
                        S11:     state_r <= EN2;
                        S00:     state_r <= IDLE;
                        S10:     state_r <= SYNC;
                        default: state_r <= EN3;
                    endcase
                end
                EX1: begin
                    case (code_s)
                        S11:     state_r <= EX2;
                        S00:     state_r <= IDLE;
                        S10:     state_r <= SYNC;
                        default: state_r <= EX1;
                    endcase
                end
                EX2: begin
                    case (code_s)
                        S10:     state_r <= EX3;
                        S01:     state_r <= EX1;
                        S00:     state_r <= SYNC;
                        default: state_r <= EX2;
                    endcase
                end
                EX3: begin
                    case (code_s)
                        S11:     state_r <= EX2;
                        S00:     state_r <= IDLE;
                        S01:     state_r <= SYNC;
                        default: state_r <= EX3;
                    endcase
                end
                SYNC: begin
                    // Lost track: wait for an empty gate before trusting beams again.
                    if (code_s == S00) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= SYNC;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef PARKING_LOT_OCCUPANCY_EN
    parking_lot_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_s),
        .dec   (dec_s),
        .count (count),
        .full  (full),
        .empty (empty)
    );
`else
    assign count = {CNT_W{1'b0}};
    assign full  = 1'b0;
    assign empty = 1'b1;
`endif

endmodule

// File: tb/tb_parking_lot_fsm_single.sv
// Directed bench for parking_lot_fsm_single (CAPACITY=2); occupancy
// expectations follow PARKING_LOT_OCCUPANCY_EN.
module tb_parking_lot_fsm_single;

    localparam int CAP = 2;
    localparam int CW  = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_sig = 1'b0;
    logic          out_sig = 1'b0;
    logic          entering;
    logic          exiting;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    int vectors = 0;
    int miscompares = 0;

    parking_lot_fsm_single #(.CAPACITY(CAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_sig   (in_sig),
        .out_sig  (out_sig),
        .entering (entering),
        .exiting  (exiting),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one sensor code, let one edge sample it, check outputs #1 later.
    task automatic step(input string tag, input logic [1:0] code,
                        input logic exp_en, input logic exp_ex, input int exp_cnt);
        {in_sig, out_sig} = code;
        @(posedge clk);
        #1;
        chk({tag, ".entering"}, int'(entering), int'(exp_en));
        chk({tag, ".exiting"},  int'(exiting),  int'(exp_ex));
`ifdef PARKING_LOT_OCCUPANCY_EN
        chk({tag, ".count"}, int'(count), exp_cnt);
        chk({tag, ".full"},  int'(full),  int'(exp_cnt == CAP));
        chk({tag, ".empty"}, int'(empty), int'(exp_cnt == 0));
`else
        chk({tag, ".count"}, int'(count), 0 * exp_cnt);
        chk({tag, ".full"},  int'(full),  0);
        chk({tag, ".empty"}, int'(empty), 1);
`endif
    endtask

    task automatic entry(input string tag, input int c0, input int c1);
        step({tag, ".10"}, 2'b10, 1'b0, 1'b0, c0);
        step({tag, ".11"}, 2'b11, 1'b0, 1'b0, c0);
        step({tag, ".01"}, 2'b01, 1'b0, 1'b0, c0);
        step({tag, ".00"}, 2'b00, 1'b1, 1'b0, c1);
    endtask

    task automatic exit_seq(input string tag, input int c0, input int c1);
        step({tag, ".01"}, 2'b01, 1'b0, 1'b0, c0);
        step({tag, ".11"}, 2'b11, 1'b0, 1'b0, c0);
        step({tag, ".10"}, 2'b10, 1'b0, 1'b0, c0);
        step({tag, ".00"}, 2'b00, 1'b0, 1'b1, c1);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step("reset", 2'b00, 1'b0, 1'b0, 0);
        rst = 1'b0;

        // Entry with pulse width check
        step("entry_idle", 2'b00, 1'b0, 1'b0, 0);
        entry("entry", 0, 1);
        step("entry_after", 2'b00, 1'b0, 1'b0, 1);
        step("entry_hold", 2'b00, 1'b0, 1'b0, 1);

        // Exit
        exit_seq("exit", 1, 0);
        step("exit_after", 2'b00, 1'b0, 1'b0, 0);

        // Reversal and abort, then prove the FSM is back in IDLE
        step("rev.10a", 2'b10, 1'b0, 1'b0, 0);
        step("rev.11",  2'b11, 1'b0, 1'b0, 0);
        step("rev.10b", 2'b10, 1'b0, 1'b0, 0);
        step("rev.00",  2'b00, 1'b0, 1'b0, 0);
        entry("rev_entry", 0, 1);

        // Illegal jump into SYNC, held long, then a clean entry
        step("sync.00", 2'b00, 1'b0, 1'b0, 1);
        for (int i = 0; i < 20; i++) begin
            step("sync.11", 2'b11, 1'b0, 1'b0, 1);
        end
        step("sync.01", 2'b01, 1'b0, 1'b0, 1);
        step("sync.00x", 2'b00, 1'b0, 1'b0, 1);
        entry("sync_entry", 1, 2);

        // Reset mid-crossing discards the partial sequence
        step("rmid.10", 2'b10, 1'b0, 1'b0, 2);
        step("rmid.11", 2'b11, 1'b0, 1'b0, 2);
        rst = 1'b1;
        step("rmid.rst", 2'b11, 1'b0, 1'b0, 0);
        rst = 1'b0;
        step("rmid.01", 2'b01, 1'b0, 1'b0, 0);
        step("rmid.00", 2'b00, 1'b0, 1'b0, 0);

        // Reset wins over a completing crossing in EN3
        step("rpri.10", 2'b10, 1'b0, 1'b0, 0);
        step("rpri.11", 2'b11, 1'b0, 1'b0, 0);
        step("rpri.01", 2'b01, 1'b0, 1'b0, 0);
        rst = 1'b1;
        step("rpri.rst", 2'b00, 1'b0, 1'b0, 0);
        rst = 1'b0;
        step("rpri.00", 2'b00, 1'b0, 1'b0, 0);

        // Saturation at both ends, pulses still emitted
        entry("sat_in1", 0, 1);
        entry("sat_in2", 1, 2);
        entry("sat_in3", 2, 2);
        exit_seq("sat_out1", 2, 1);
        exit_seq("sat_out2", 1, 0);
        exit_seq("sat_out3", 0, 0);
        step("sat_end", 2'b00, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
